n64_vbus_pattern_tx: RTL



---
 rtl/n64_vbus_pattern_tx.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/n64_vbus_pattern_tx.sv
// n64_vbus_pattern_tx: N64 digital video bus transmitter producing a self-timed
// 240p stream (sync word + 7-bit R/G/B per pixel, framed by nVDSYNC) carrying
// selectable test patterns.
//
// Ports:
//   VCLK          video clock, all logic on the rising edge
//   nVRST         synchronous active-low reset
//   en_i          pattern enable (0 = black active video, sync continues)
//   pattern_i     0 bars, 1 gray ramp, 2 solid, 3 checkerboard
//   solid_rgb_i   {R,G,B} 7 bits each, used by the solid pattern
//   nVDSYNC_o     low during the sync word of each pixel
//   VD_o          sync word or color sample
//   frame_start_o one-cycle pulse with the first sync word of each frame
module n64_vbus_pattern_tx #(
    parameter int unsigned H_TOTAL     = 773,
    parameter int unsigned H_SYNC      = 57,
    parameter int unsigned CLAMP_LEN   = 32,
    parameter int unsigned H_ACT_START = 128,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_TOTAL     = 263,
    parameter int unsigned V_SYNC      = 3,
    parameter int unsigned V_ACT_START = 20,
    parameter int unsigned V_ACTIVE    = 240,
    parameter int unsigned BAR_W       = 80
) (
    input  logic        VCLK,
    input  logic        nVRST,
    input  logic        en_i,
    input  logic [1:0]  pattern_i,
    input  logic [20:0] solid_rgb_i,
    output logic        nVDSYNC_o,
    output logic [6:0]  VD_o,
    output logic        frame_start_o
);

    localparam int unsigned HW  = $clog2(H_TOTAL);
    localparam int unsigned VW  = $clog2(V_TOTAL);
    localparam int unsigned BW  = $clog2(BAR_W + 1);
    localparam int unsigned XQW = HW - 2;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_SOLID = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    logic [1:0]     r_phase;
    logic [HW-1:0]  r_hcnt;
    logic [VW-1:0]  r_vcnt;
    logic           r_en;
    logic [1:0]     r_pat;
    logic [20:0]    r_solid;
    logic [BW-1:0]  r_bar_cnt;
    logic [2:0]     r_bar_idx;

    logic           w_h_last;
    logic           w_v_last;
    logic [HW-1:0]  w_hcnt_nxt;
    logic [VW-1:0]  w_vcnt_nxt;
    logic           w_frame_start;
    logic           w_nhs;
    logic           w_nvs;
    logic           w_nclamp;
    logic           w_ncs;
    logic           w_active;
    logic [XQW-1:0] w_xq;
    logic           w_x4;
    logic           w_y4;
    logic [6:0]     w_r;
    logic [6:0]     w_g;
    logic [6:0]     w_b;
    logic [6:0]     w_vd;
    logic           w_nvdsync;

    // Counter wrap, sync flags and active-window decode from the current state
    always_comb begin
        w_h_last      = (32'(r_hcnt) == H_TOTAL - 1);
        w_v_last      = (32'(r_vcnt) == V_TOTAL - 1);
        w_hcnt_nxt    = w_h_last ? '0 : r_hcnt + HW'(1);
        w_vcnt_nxt    = w_v_last ? '0 : r_vcnt + VW'(1);
        w_frame_start = (r_phase == 2'd0) && (r_hcnt == '0) && (r_vcnt == '0);

        w_nhs    = (32'(r_hcnt) >= H_SYNC);
        w_nvs    = (32'(r_vcnt) >= V_SYNC);
        w_nclamp = !((32'(r_hcnt) >= H_SYNC) && (32'(r_hcnt) < H_SYNC + CLAMP_LEN));
        w_ncs    = w_nvs ? w_nhs : ~w_nhs;

        w_active = (32'(r_hcnt) >= H_ACT_START) && (32'(r_hcnt) < H_ACT_START + H_ACTIVE) &&
                   (32'(r_vcnt) >= V_ACT_START) && (32'(r_vcnt) < V_ACT_START + V_ACTIVE);

        // Only x>>2 and bit 4 of x/y are ever needed
        w_xq = XQW'((r_hcnt - HW'(H_ACT_START)) >> 2);
        w_x4 = 1'((r_hcnt - HW'(H_ACT_START)) >> 4);
        w_y4 = 1'((r_vcnt - VW'(V_ACT_START)) >> 4);
    end

    // Pixel color from the frame-latched controls
    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (w_active && r_en) begin
            case (r_pat)
                PAT_BARS: begin
                    // Index bits map straight onto the channel enables; 7 is black
                    w_r = {7{~r_bar_idx[1]}};
                    w_g = {7{~r_bar_idx[2]}};
                    w_b = {7{~r_bar_idx[0]}};
                end
                PAT_RAMP: begin
                    w_r = (w_xq > XQW'(127)) ? 7'h7F : 7'(w_xq);
                    w_g = w_r;
                    w_b = w_r;
                end
                PAT_SOLID: begin
                    w_r = r_solid[20:14];
                    w_g = r_solid[13:7];
                    w_b = r_solid[6:0];
                end
                PAT_CHECK: begin
                    w_r = {7{w_x4 ^ w_y4}};
                    w_g = w_r;
                    w_b = w_r;
                end
                default: ;
            endcase
        end
    end

    // Word multiplexer: sync word in phase 0, then R, G, B
    always_comb begin
        w_nvdsync = 1'b1;
        w_vd      = '0;
        case (r_phase)
            2'd0: begin
                w_nvdsync = 1'b0;
                w_vd      = {3'b000, w_nvs, w_nclamp, w_nhs, w_ncs};
            end
            2'd1:    w_vd = w_r;
            2'd2:    w_vd = w_g;
            default: w_vd = w_b;
        endcase
    end

    // Phase / pixel / line counters
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            r_phase <= '0;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
        end else begin
            r_phase <= r_phase + 2'd1;
            if (r_phase == 2'd3) begin
                r_hcnt <= w_hcnt_nxt;
                if (w_h_last) begin
                    r_vcnt <= w_vcnt_nxt;
                end
            end
        end
    end

    // Controls are sampled once per frame so a frame is never mixed
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            r_en    <= 1'b0;
            r_pat   <= '0;
            r_solid <= '0;
        end else if (w_frame_start) begin
            r_en    <= en_i;
            r_pat   <= pattern_i;
            r_solid <= solid_rgb_i;
        end
    end

    // Bar index tracker: restarts at the pixel before the window, saturates at 7
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (r_phase == 2'd3) begin
            if (w_hcnt_nxt == HW'(H_ACT_START)) begin
                r_bar_cnt <= '0;
                r_bar_idx <= '0;
            end else if (r_bar_cnt == BW'(BAR_W - 1)) begin
                r_bar_cnt <= '0;
                if (r_bar_idx != 3'd7) begin
                    r_bar_idx <= r_bar_idx + 3'd1;
                end
            end else begin
                r_bar_cnt <= r_bar_cnt + BW'(1);
            end
        end
    end

    // Output registers
    always_ff @(posedge VCLK) begin
        if (!nVRST) begin
            nVDSYNC_o     <= 1'b1;
            VD_o          <= '0;
            frame_start_o <= 1'b0;
        end else begin
            nVDSYNC_o     <= w_nvdsync;
            VD_o          <= w_vd;
            frame_start_o <= w_frame_start;
        end
    end

endmodule
